instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Fetch stage between the program counter and decode. Detects each new PC value, issues a word read to instruction memory over a valid/ready handshake, buffers returned instructions with their PCs in an in-order queue, and presents them to decode. Back-pressures the program counter through its stall input and discards wrong-path work on a jump flush.

## Interface
- QUEUE_DEPTH, 4, instruction queue entries; power of two, ≥2
- MAX_OUTSTANDING, 2, imem requests in flight (accepted, response pending)

- clock  in  1  single clock, all state on posedge
- resetN  in  1  synchronous, active-low reset
- pcValue  in  32  current PC from the program counter
- pcToggle  in  1  PC change toggle; a new PC exists when it differs from the last consumed toggle
- pcStall  out  1  stall to the program counter
- flush  in  1  jump taken this cycle; kill all wrong-path state
- imemReqValid  out  1  request valid
- imemReqAddr  out  32  word address (= PC)
- imemReqReady  in  1  memory accepts request
- imemRespValid  in  1  in-order response valid (always accepted)
- imemRespData  in  32  instruction word
- instValid  out  1  queue head valid
- instData  out  32  head instruction
- instPc  out  32  head PC
- decodeReady  in  1  decode pops head when instValid && decodeReady

## Operation
- lastToggle register: reset 1, matching the PC's reset toggle, so the pre-start PC is never fetched. newPc = (pcToggle != lastToggle) && !flush.
- Request: imemReqValid = newPc && credit, where credit = (occupancy + inflight < QUEUE_DEPTH) && (inflight < MAX_OUTSTANDING). imemReqAddr = pcValue. On handshake: lastToggle <= pcToggle, inflight+1, PC pushed to the PC-tag FIFO (depth MAX_OUTSTANDING).
- pcStall = newPc && !(imemReqValid && imemReqReady). The PC holds until its fetch is accepted. Never asserted when no new PC is pending.
- Response: if discard > 0, decrement discard and drop. Otherwise push {imemRespData, tag FIFO head} into the queue, pop the tag, inflight−1.
- Pop: instValid && decodeReady advances head. Push and pop in the same cycle are legal at any occupancy, including full: credits guarantee no overflow.
- Flush: queue emptied, tag FIFO emptied, lastToggle <= pcToggle (wrong-path PC consumed), discard <= discard + inflight − (response this cycle ? 1 : 0), inflight <= 0, no request issued, pcStall = 0. Flush dominates a same-cycle push, pop, and new PC.
- Pointers: log2(QUEUE_DEPTH)+1 bits each; full/empty from the MSB compare; wrap-around is natural.
- Reset (resetN=0): queue empty, inflight 0, discard 0, lastToggle 1, instValid 0, imemReqValid 0, pcStall 0. Reset mid-flight drops all responses not yet returned; the memory side is reset together with this block.

## Timing
- Request is combinational in the same cycle the new PC appears (PC registered at posedge t, request in cycle t).
- A response in cycle r gives instValid=1 in cycle r+1 when the queue was empty (registered queue, no bypass).
- Throughput: 1 instruction/cycle with single-cycle memory and decodeReady held high.
- Flush in cycle f: instValid=0 in f+1. The jump target PC arrives from the program counter at f+1, and its request issues at f+1.
- Outputs are registered, except imemReqValid, imemReqAddr and pcStall.

## Configuration
- FETCH_ALIGN_CHECK_EN:
  - Defined: adds output fetchAddrError (1 bit, reset 0). A new PC with pcValue[1:0] != 0 is not sent to memory. It is consumed as a single queue entry with instData=32'h0000_0000 (nop) and fetchAddrError=1, flowing in order at the head.
  - Undefined: no port. Addresses go to memory unchanged.

## Structure
- Shared package: int_t (32-bit), RESET_PC 32'h0000_3000, NOP_INSTR, and the fetch entry struct {data, pc, addrError}.
- One sub-module, fetch_fifo: parameterized synchronous FIFO, used for both the instruction queue and the PC-tag FIFO, with a flush-clear input.

## Test plan
- Reset release with PC starting at 0x3000, single-cycle memory, decodeReady=1 → instPc 0x3000, 0x3004, 0x3008 on consecutive cycles; pcStall never 1.
- decodeReady=0 for 10 cycles, memory always ready → exactly QUEUE_DEPTH (4) entries fetched, then pcStall held high, no imemReqValid with inflight+occupancy=4; on release, all 4 drain in order.
- imemReqReady=0 for 3 cycles on PC 0x3010 → pcStall=1 for exactly those 3 cycles, pcValue stays 0x3010, one request issued.
- Two requests outstanding (0x3020, 0x3024), 3-cycle latency, flush asserted → both responses dropped (discard 2→0); the jump target 0x4000 appears as the next instPc.
- Flush coincident with a response and a decode pop → queue empty next cycle, discard = inflight−1, no entry from the response enters the queue.
- With FETCH_ALIGN_CHECK_EN, PC 0x3002 → no memory request issued; head shows instData 0, fetchAddrError=1, instPc 0x3002.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The FETCH_ALIGN_CHECK_EN build carries the addrError flag of fetch_entry_t through the queue.
package instruction_fetch_queue_pkg;

    typedef logic [31:0] int_t;

    localparam int_t RESET_PC  = 32'h0000_3000;
    localparam int_t NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        int_t data;
        int_t pc;
        logic addr_error;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_misaligned(input int_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_fifo.sv
// Synchronous FIFO with a registered head and a flush-clear input.
// DEPTH must be a power of two and at least 2; a push and a pop may share a cycle even when full.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit; full and empty come from comparing it.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetN && !clear && push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count     = wr_ptr - rd_ptr;
        head_data = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: detects new PCs, issues imem reads under a credit limit, queues responses for decode.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned PCs into in-order nop entries flagged fetchAddrError.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] pcValue,
    input  logic        pcToggle,
    output logic        pcStall,
    input  logic        flush,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        instValid,
    output logic [31:0] instData,
    output logic [31:0] instPc,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        fetchAddrError,
`endif
    input  logic        decodeReady
);

    localparam int QAW       = $clog2(QUEUE_DEPTH);
    localparam int TAW       = $clog2(MAX_OUTSTANDING);
    localparam int DISCARD_W = 8;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam int ENTRY_W   = FETCH_ENTRY_W;
`else
    localparam int ENTRY_W   = 64;
`endif

    logic                 last_toggle;
    logic [DISCARD_W-1:0] discard;

    logic new_pc;
    logic credit;
    logic misaligned;
    logic err_take;
    logic req_fire;
    logic resp_accept;
    logic resp_drop;
    logic q_push;
    logic q_pop;

    logic [ENTRY_W-1:0] q_push_bits;
    logic [ENTRY_W-1:0] q_head_bits;
    logic [QAW:0]       q_count;
    logic               q_empty;
    logic               q_full;

    int_t               tag_head;
    logic [TAW:0]       tag_count;
    logic               tag_empty;
    logic               tag_full;

    // The tag FIFO holds exactly one PC per accepted, non-discarded request,
    // so its count doubles as the in-flight counter.
    always_comb begin
        new_pc = resetN && (pcToggle != last_toggle) && !flush;
        credit = ((int'(q_count) + int'(tag_count)) < QUEUE_DEPTH) && !tag_full;

`ifdef FETCH_ALIGN_CHECK_EN
        misaligned = is_misaligned(pcValue);
        // Only with nothing in flight can the nop entry be appended without overtaking a fetch.
        err_take   = new_pc && misaligned && tag_empty && !q_full;
`else
        misaligned = 1'b0;
        err_take   = 1'b0;
`endif

        imemReqValid = new_pc && credit && !misaligned;
        imemReqAddr  = pcValue;
        req_fire     = imemReqValid && imemReqReady;
        pcStall      = new_pc && !(req_fire || err_take);

        resp_drop   = imemRespValid && (discard != '0);
        resp_accept = imemRespValid && (discard == '0) && !tag_empty;

        q_push = (resp_accept || err_take) && !flush;
        q_pop  = !q_empty && decodeReady && !flush;

`ifdef FETCH_ALIGN_CHECK_EN
        if (err_take) begin
            q_push_bits = {NOP_INSTR, pcValue, 1'b1};
        end else begin
            q_push_bits = {imemRespData, tag_head, 1'b0};
        end
`else
        q_push_bits = {imemRespData, tag_head};
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            last_toggle <= 1'b1;
        end else if (flush || req_fire || err_take) begin
            last_toggle <= pcToggle;
        end
    end

    // Responses already owed by memory when a flush hits are counted here and dropped on return.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            discard <= '0;
        end else if (flush) begin
            discard <= discard + DISCARD_W'(tag_count) - DISCARD_W'(imemRespValid);
        end else if (resp_drop) begin
            discard <= discard - 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .resetN    (resetN),
        .clear     (flush),
        .push      (req_fire),
        .push_data (pcValue),
        .pop       (resp_accept && !flush),
        .head_data (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clock     (clock),
        .resetN    (resetN),
        .clear     (flush),
        .push      (q_push),
        .push_data (q_push_bits),
        .pop       (q_pop),
        .head_data (q_head_bits),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_entry_t q_head;

    always_comb begin
        q_head         = fetch_entry_t'(q_head_bits);
        instValid      = !q_empty;
        instData       = q_head.data;
        instPc         = q_head.pc;
        fetchAddrError = q_head.addr_error;
    end
`else
    always_comb begin
        instValid = !q_empty;
        instData  = q_head_bits[63:32];
        instPc    = q_head_bits[31:0];
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: random PC/memory/decode traffic against a queue-level model.
// Build with FETCH_ALIGN_CHECK_EN defined to also exercise misaligned-PC handling.
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    localparam int QD = 4;
    localparam int MO = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] pcValue;
    logic        pcToggle;
    logic        pcStall;
    logic        flush;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPc;
    logic        decodeReady;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetchAddrError;
`endif

    always #5 clock = ~clock;

    instruction_fetch_queue #(
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .pcValue        (pcValue),
        .pcToggle       (pcToggle),
        .pcStall        (pcStall),
        .flush          (flush),
        .imemReqValid   (imemReqValid),
        .imemReqAddr    (imemReqAddr),
        .imemReqReady   (imemReqReady),
        .imemRespValid  (imemRespValid),
        .imemRespData   (imemRespData),
        .instValid      (instValid),
        .instData       (instData),
        .instPc         (instPc),
`ifdef FETCH_ALIGN_CHECK_EN
        .fetchAddrError (fetchAddrError),
`endif
        .decodeReady    (decodeReady)
    );

    // Scoreboard: fetched entries in program order, {addrError, pc}; the first occ have arrived.
    logic [32:0] exp_q[$];
    int          due_q[$];
    int_t        addr_q[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   occ = 0;
    int   inflight = 0;
    int   discard = 0;
    int   cyc = 0;
    int   pop_count = 0;
    bit   pending = 1'b0;
    int_t pc;
    logic tog;

    int   new_pct, ready_pct, dec_pct, lat_min, lat_max, flush_pct;
    bit   force_flush = 1'b0;
    int_t force_target;
    int_t flush_target;

    function automatic int_t mem_data(input int_t a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Driver: inputs for the next cycle, applied just after the rising edge.
    task automatic apply_inputs();
        cyc++;
        if (flush) begin
            pc      = flush_target;
            tog     = ~tog;
            pending = 1'b1;
        end else if (!pending && ($urandom_range(99) < new_pct)) begin
            pc      = pc + 32'd4;
            tog     = ~tog;
            pending = 1'b1;
        end
        pcValue  = pc;
        pcToggle = tog;

        if (force_flush) begin
            flush        = 1'b1;
            flush_target = force_target;
            force_flush  = 1'b0;
        end else if ($urandom_range(99) < flush_pct) begin
            flush        = 1'b1;
            flush_target = $urandom & 32'hFFFF_FFFC;
        end else begin
            flush = 1'b0;
        end

        imemReqReady = ($urandom_range(99) < ready_pct);
        decodeReady  = ($urandom_range(99) < dec_pct);

        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imemRespValid = 1'b1;
            imemRespData  = mem_data(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = $urandom;
        end
    endtask

    // Reference model and checks, evaluated mid-cycle on the falling edge.
    task automatic model_cycle();
        bit exp_valid;
        bit req_exp;
        bit stall_exp;
        bit take;
        exp_valid = (occ > 0);
        req_exp   = 1'b0;
        stall_exp = 1'b0;
        take      = 1'b0;

        check("instValid", {31'b0, instValid}, {31'b0, exp_valid});

        if (pending && !flush) begin
            if (ALIGN && pc[1:0] != 2'b00) begin
                take      = (inflight == 0) && (occ < QD);
                stall_exp = !take;
            end else begin
                req_exp   = ((occ + inflight) < QD) && (inflight < MO);
                stall_exp = !(req_exp && imemReqReady);
            end
        end
        check("imemReqValid", {31'b0, imemReqValid}, {31'b0, req_exp});
        check("pcStall", {31'b0, pcStall}, {31'b0, stall_exp});
        if (req_exp) begin
            check("imemReqAddr", imemReqAddr, pc);
        end

        if (flush) begin
            exp_q.delete();
            occ      = 0;
            inflight = 0;
            discard  = addr_q.size();
            pending  = 1'b0;
        end else begin
            if (instValid && decodeReady) begin
                pop_count++;
            end
            if (exp_valid && decodeReady) begin
                check("instPc", instPc, exp_q[0][31:0]);
                check("instData", instData, exp_q[0][32] ? NOP_INSTR : mem_data(exp_q[0][31:0]));
`ifdef FETCH_ALIGN_CHECK_EN
                check("fetchAddrError", {31'b0, fetchAddrError}, {31'b0, exp_q[0][32]});
`endif
                void'(exp_q.pop_front());
                occ--;
            end
            if (imemRespValid) begin
                if (discard > 0) begin
                    discard--;
                end else begin
                    occ++;
                    inflight--;
                end
            end
            if (req_exp && imemReqReady) begin
                exp_q.push_back({1'b0, pc});
                inflight++;
                addr_q.push_back(pc);
                due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                pending = 1'b0;
            end
            if (take) begin
                exp_q.push_back({1'b1, pc});
                occ++;
                pending = 1'b0;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_inputs();
            @(negedge clock);
            model_cycle();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_knobs(input int np, input int rp, input int dp,
                             input int lmin, input int lmax, input int fp);
        new_pct   = np;
        ready_pct = rp;
        dec_pct   = dp;
        lat_min   = lmin;
        lat_max   = lmax;
        flush_pct = fp;
    endtask

    initial begin
        int pops_before;

        // Clock/reset: the PC sits on its pre-start value with toggle 1 during reset.
        pc            = RESET_PC - 32'd4;
        tog           = 1'b1;
        resetN        = 1'b0;
        pcValue       = pc;
        pcToggle      = tog;
        flush         = 1'b0;
        imemReqReady  = 1'b1;
        imemRespValid = 1'b0;
        imemRespData  = '0;
        decodeReady   = 1'b1;
        set_knobs(100, 100, 100, 1, 1, 0);

        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("reset_instValid", {31'b0, instValid}, 32'd0);
            check("reset_imemReqValid", {31'b0, imemReqValid}, 32'd0);
            check("reset_pcStall", {31'b0, pcStall}, 32'd0);
            @(posedge clock);
            #1;
        end
        resetN = 1'b1;

        // Single-cycle memory, decode always ready: one instruction per cycle from 0x3000.
        run_cycles(6);
        pops_before = pop_count;
        run_cycles(16);
        check("throughput_pops", pop_count - pops_before, 32'd16);

        // Decode stalled: queue fills to depth, PC is held, then drains in order.
        set_knobs(100, 100, 0, 1, 1, 0);
        run_cycles(10);
        set_knobs(100, 100, 100, 1, 1, 0);
        run_cycles(8);

        // Memory not ready for three cycles.
        set_knobs(100, 0, 100, 1, 1, 0);
        run_cycles(3);
        set_knobs(100, 100, 100, 1, 1, 0);
        run_cycles(6);

        // Three-cycle latency with two requests outstanding, then a jump to 0x4000.
        set_knobs(100, 100, 100, 3, 3, 0);
        run_cycles(4);
        force_flush  = 1'b1;
        force_target = 32'h0000_4000;
        run_cycles(14);

        // Random traffic with variable latency and occasional flushes.
        set_knobs(70, 70, 70, 1, 4, 3);
        run_cycles(1500);

        // Flush-heavy traffic so flushes coincide with responses and pops.
        set_knobs(90, 90, 90, 1, 2, 15);
        run_cycles(400);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PCs bypass memory and arrive as flagged nops.
        set_knobs(100, 100, 100, 1, 1, 0);
        force_flush  = 1'b1;
        force_target = 32'h0000_3002;
        run_cycles(10);
        force_flush  = 1'b1;
        force_target = 32'h0000_5000;
        run_cycles(10);
`endif

        // Quiet drain.
        set_knobs(0, 100, 100, 1, 1, 0);
        run_cycles(20);
        check("drain_instValid", {31'b0, instValid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
